motion_seq: RTL

- Command sequencer that drives one step_gen channel: accepts queued motion commands, turns them into a cycle-by-cycle velocity profile, and issues position presets.
- Each move command is a constant-acceleration segment: velocity increases by a signed accel per clock for N clocks.
- A set-position command pulses set_position with a preset value.
- Sits between the host/bus command interface and step_gen's velocity, data_in and set_position inputs.

---
 rtl/motion_seq_pkg.sv | 30 +++
 rtl/motion_cmd_fifo.sv | 68 ++++++
 rtl/motion_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/motion_seq_pkg.sv
// Shared encodings for the motion command sequencer: command types, FSM states
// and the layout of a queued command word {type, value, duration}.
package motion_seq_pkg;

  localparam int unsigned DUR_W   = 32;
  localparam int unsigned DUR_LSB = 0;
  localparam int unsigned VAL_LSB = DUR_W;

  localparam logic CMD_MOVE   = 1'b0;
  localparam logic CMD_SETPOS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETPOS = 3'd3,
    ST_NEXT   = 3'd4
  } state_e;

  // Command word width for a given velocity width.
  function automatic int unsigned cmd_w(input int unsigned vw);
    return 1 + vw + DUR_W;
  endfunction

  // Bit position of the command-type flag (MSB of the word).
  function automatic int unsigned type_bit(input int unsigned vw);
    return DUR_W + vw;
  endfunction

endpackage

// File: rtl/motion_cmd_fifo.sv
// Single-clock command FIFO with async reset, flush, and registered full/empty/level.
module motion_cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data_c,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_d;

  // Qualified handshakes and next occupancy; flush wins over push/pop.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    level_d = level;
    if (flush) begin
      level_d = '0;
    end else begin
      level_d = level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/motion_seq.sv
// Motion command sequencer: queues MOVE/SETPOS commands and turns them into a
// saturating constant-acceleration velocity profile plus position presets for step_gen.
module motion_seq
  import motion_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned VW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_type,
  input  logic [VW-1:0]          cmd_value,
  input  logic [31:0]            cmd_duration,
  input  logic                   start,
  input  logic                   abort,
  output logic signed [VW-1:0]   velocity,
  output logic [VW-1:0]          data_out,
  output logic                   set_position,
  output logic                   busy,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned CW    = cmd_w(VW);
  localparam int unsigned TYPEB = type_bit(VW);

  // Symmetric clamp range; the most-negative code is excluded.
  localparam logic signed [VW:0] VEL_MAX = {2'b00, {(VW-1){1'b1}}};
  localparam logic signed [VW:0] VEL_MIN = {2'b11, {(VW-2){1'b0}}, 1'b1};

  state_e                state_q;
  state_e                state_d;
  logic [CW-1:0]         cmd_word;
  logic [CW-1:0]         head;
  logic                  head_type;
  logic [VW-1:0]         head_value;
  logic [DUR_W-1:0]      head_dur;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_flush;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic signed [VW-1:0]  accel_q;
  logic signed [VW-1:0]  accel_d;
  logic [DUR_W-1:0]      cnt_q;
  logic [DUR_W-1:0]      cnt_d;
  logic signed [VW-1:0]  vel_d;
  logic [VW-1:0]         data_d;
  logic                  setpos_d;
  logic                  under_d;
  logic signed [VW:0]    sum;
  logic signed [VW-1:0]  sat_vel;

  assign cmd_word  = {cmd_type, cmd_value, cmd_duration};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  assign head_type  = head[TYPEB];
  assign head_value = head[VAL_LSB +: VW];
  assign head_dur   = head[DUR_LSB +: DUR_W];

  motion_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .wr_data   (cmd_word),
    .pop       (fifo_pop),
    .rd_data_c (head),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Saturating velocity update, evaluated one bit wider than the datapath.
  always_comb begin
    sum = {velocity[VW-1], velocity} + {accel_q[VW-1], accel_q};
    if (sum > VEL_MAX) begin
      sat_vel = VEL_MAX[VW-1:0];
    end else if (sum < VEL_MIN) begin
      sat_vel = VEL_MIN[VW-1:0];
    end else begin
      sat_vel = sum[VW-1:0];
    end
  end

  // Next-state and datapath decisions; abort overrides every state.
  always_comb begin
    state_d    = state_q;
    vel_d      = velocity;
    accel_d    = accel_q;
    cnt_d      = cnt_q;
    data_d     = data_out;
    setpos_d   = 1'b0;
    under_d    = underrun;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    if (abort) begin
      state_d    = ST_IDLE;
      vel_d      = '0;
      fifo_flush = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            under_d = 1'b0;
            if (!fifo_empty) state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          fifo_pop = 1'b1;
          if (head_type == CMD_SETPOS) begin
            data_d   = head_value;
            setpos_d = 1'b1;
            state_d  = ST_SETPOS;
          end else begin
            accel_d = head_value;
            cnt_d   = head_dur;
            state_d = (head_dur != '0) ? ST_RUN : ST_NEXT;
          end
        end
        ST_RUN: begin
          vel_d = sat_vel;
          cnt_d = cnt_q - DUR_W'(1);
          if (cnt_q == DUR_W'(1)) state_d = ST_NEXT;
        end
        ST_SETPOS: begin
          state_d = ST_NEXT;
        end
        ST_NEXT: begin
          if (!fifo_empty) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
            if (velocity != '0) begin
              vel_d   = '0;
              under_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      velocity     <= '0;
      accel_q      <= '0;
      cnt_q        <= '0;
      data_out     <= '0;
      set_position <= 1'b0;
      underrun     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      velocity     <= vel_d;
      accel_q      <= accel_d;
      cnt_q        <= cnt_d;
      data_out     <= data_d;
      set_position <= setpos_d;
      underrun     <= under_d;
      busy         <= (state_d != ST_IDLE);
    end
  end

endmodule
